// File: rtl/envelope_gen.sv
// envelope_gen: per-voice ADSR amplitude envelope.
// A free-running prescaler produces envelope ticks; gate edges move the
// stage machine, ticks step the level, and the incoming sample is scaled
// by the registered level with a one-cycle registered multiply.
module envelope_gen #(
  parameter int unsigned TICK_DIV      = 12000,
  parameter int unsigned ATTACK_STEP   = 4,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       gate,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic [7:0] level,
  output logic [2:0] env_state,
  output logic       active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [15:0] TDIV_M1   = 16'(TICK_DIV - 1);
  localparam logic [8:0]  ATK_STEP9 = 9'(ATTACK_STEP);
  localparam logic [7:0]  DEC_STEP8 = 8'(DECAY_STEP);
  localparam logic [7:0]  REL_STEP8 = 8'(RELEASE_STEP);
  localparam logic [7:0]  SUS_LVL8  = 8'(SUSTAIN_LEVEL);
  // level - DECAY_STEP <= SUSTAIN_LEVEL  <=>  level <= SUSTAIN_LEVEL + DECAY_STEP,
  // which sidesteps the underflow case entirely.
  localparam logic [9:0]  DEC_LIMIT = 10'(SUSTAIN_LEVEL + DECAY_STEP);

  logic [15:0] presc_q, presc_d;
  logic        gate_q, gate_d;
  state_e      state_q, state_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  sample_out_q, sample_out_d;

  logic tick, rise, fall;
  logic [8:0] atk_sum;

  // Prescaler: free-running, never resynchronised to the gate.
  always_comb begin
    tick    = (presc_q == TDIV_M1);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
  end

  // Gate edge detection against the one-cycle delayed gate.
  always_comb begin
    gate_d = gate;
    rise   = gate & ~gate_q;
    fall   = ~gate & gate_q;
  end

  // Stage machine and level stepping; edges win over ticks so a level
  // never steps in the same cycle a stage change is forced by the key.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    atk_sum = {1'b0, level_q} + ATK_STEP9;
    if (rise) begin
      state_d = S_ATTACK;                 // legato: level carried over
    end else if (fall) begin
      if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)
        state_d = S_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        S_ATTACK: begin
          if (atk_sum >= 9'd255) begin
            level_d = 8'd255;
            state_d = S_DECAY;
          end else begin
            level_d = atk_sum[7:0];
          end
        end
        S_DECAY: begin
          if ({2'b00, level_q} <= DEC_LIMIT) begin
            level_d = SUS_LVL8;
            state_d = S_SUSTAIN;
          end else begin
            level_d = level_q - DEC_STEP8;
          end
        end
        S_SUSTAIN: level_d = level_q;
        S_RELEASE: begin
          if (level_q <= REL_STEP8) begin
            level_d = 8'd0;
            state_d = S_IDLE;
          end else begin
            level_d = level_q - REL_STEP8;
          end
        end
        default: level_d = 8'd0;          // IDLE stays silent
      endcase
    end
  end

  // Scaling: upper byte of the 16-bit product, using this cycle's level.
  always_comb begin
    sample_out_d = 8'((16'(sample_in) * 16'(level_q)) >> 8);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      presc_q      <= 16'd0;
      gate_q       <= 1'b0;
      state_q      <= S_IDLE;
      level_q      <= 8'd0;
      sample_out_q <= 8'd0;
    end else begin
      presc_q      <= presc_d;
      gate_q       <= gate_d;
      state_q      <= state_d;
      level_q      <= level_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign sample_out = sample_out_q;
  assign level      = level_q;
  assign env_state  = state_q;
  assign active     = (state_q != S_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Bench for envelope_gen: directed walk through the envelope stages, then
// randomized gate/reset/sample traffic checked every cycle against a
// behavioural model of the stage rules.
module tb_envelope_gen;
  localparam int TDIV = 4;
  localparam int AS   = 64;
  localparam int DS   = 32;
  localparam int SL   = 128;
  localparam int RS   = 64;

  logic       clk = 1'b0;
  logic       nrst;
  logic       gate;
  logic [7:0] sample_in;
  logic [7:0] sample_out;
  logic [7:0] level;
  logic [2:0] env_state;
  logic       active;

  int checks   = 0;
  int failures = 0;

  // Model state: stage 0..4, level, prescaler count, delayed gate.
  int m_state = 0;
  int m_level = 0;
  int m_presc = 0;
  int m_sout  = 0;
  bit m_gq    = 1'b0;

  envelope_gen #(
    .TICK_DIV(TDIV), .ATTACK_STEP(AS), .DECAY_STEP(DS),
    .SUSTAIN_LEVEL(SL), .RELEASE_STEP(RS)
  ) dut (
    .clk(clk), .nrst(nrst), .gate(gate), .sample_in(sample_in),
    .sample_out(sample_out), .level(level), .env_state(env_state),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: predict from the current inputs, step the DUT, compare.
  task automatic cycle();
    int ns, nl, np, no;
    bit ngq, tk, rise, fall;
    if (!nrst) begin
      ns = 0; nl = 0; np = 0; no = 0; ngq = 1'b0;
    end else begin
      tk   = (m_presc == TDIV - 1);
      np   = tk ? 0 : m_presc + 1;
      rise = gate && !m_gq;
      fall = !gate && m_gq;
      no   = (int'(sample_in) * m_level) / 256;
      ngq  = gate;
      ns   = m_state;
      nl   = m_level;
      if (rise) ns = 1;
      else if (fall) begin
        if (m_state >= 1 && m_state <= 3) ns = 4;
      end else if (tk) begin
        case (m_state)
          1: if (m_level + AS >= 255) begin nl = 255; ns = 2; end else nl = m_level + AS;
          2: if (m_level - DS <= SL) begin nl = SL; ns = 3; end else nl = m_level - DS;
          4: if (m_level <= RS) begin nl = 0; ns = 0; end else nl = m_level - RS;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_state = ns; m_level = nl; m_presc = np; m_sout = no; m_gq = ngq;
    chk("model_state", env_state, m_state);
    chk("model_level", level, m_level);
    chk("model_sout", sample_out, m_sout);
    chk("model_active", active, (m_state != 0));
  endtask

  initial begin
    int seq[$];
    int exp_seq[8] = '{64, 128, 192, 255, 223, 191, 159, 128};
    int prev, n;

    nrst = 1'b0; gate = 1'b1; sample_in = 8'd200;

    // 1. reset with gate held, then attack climb
    repeat (3) begin
      cycle();
      chk("rst_state", env_state, 0);
      chk("rst_level", level, 0);
      chk("rst_sout", sample_out, 0);
      chk("rst_active", active, 0);
    end
    nrst = 1'b1;
    cycle();
    chk("first_attack", env_state, 1);
    chk("first_level", level, 0);
    for (int i = 0; i < 80 && seq.size() < 8; i++) begin
      prev = level;
      cycle();
      if (level != 8'(prev)) seq.push_back(int'(level));
    end
    chk("seq_len", seq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("adsr_seq", (i < seq.size()) ? seq[i] : -1, exp_seq[i]);

    // 2. sustain hold
    chk("sustain_state", env_state, 3);
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk("sustain_hold", level, 128);
    end
    chk("sustain_sout", sample_out, 100);

    // 3. release to idle
    gate = 1'b0;
    cycle();
    chk("rel_state", env_state, 4);
    chk("rel_level", level, 128);
    for (int i = 0; i < 8 && level == 8'd128; i++) cycle();
    chk("rel_step", level, 64);
    for (int i = 0; i < 8 && env_state != 3'd0; i++) cycle();
    chk("idle_state", env_state, 0);
    chk("idle_level", level, 0);
    chk("idle_active", active, 0);
    cycle();
    chk("idle_sout", sample_out, 0);

    // 4. legato retrigger from release at 64
    gate = 1'b1;
    for (int i = 0; i < 100 && env_state != 3'd3; i++) cycle();
    chk("reach_sustain", env_state, 3);
    gate = 1'b0;
    for (int i = 0; i < 20 && level != 8'd64; i++) cycle();
    chk("rel64_level", level, 64);
    chk("rel64_state", env_state, 4);
    gate = 1'b1;
    cycle();
    chk("retrig_state", env_state, 1);
    chk("retrig_level", level, 64);
    for (int i = 0; i < 8 && level == 8'd64; i++) cycle();
    chk("retrig_step", level, 128);

    // 5. gate fall coinciding with a tick in attack at 128
    for (int i = 0; i < 8 && m_presc != TDIV - 1; i++) cycle();
    chk("pre_tick_level", level, 128);
    gate = 1'b0;
    cycle();
    chk("edge_tick_state", env_state, 4);
    chk("edge_tick_level", level, 128);

    // 6. reset during decay, prescaler restarts
    for (int i = 0; i < 40 && env_state != 3'd0; i++) cycle();
    gate = 1'b1;
    for (int i = 0; i < 100 && env_state != 3'd2; i++) cycle();
    chk("reach_decay", env_state, 2);
    nrst = 1'b0;
    cycle();
    chk("mid_rst_state", env_state, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_sout", sample_out, 0);
    chk("mid_rst_active", active, 0);
    nrst = 1'b1;
    n = 0;
    while (level == 8'd0 && n < 20) begin
      cycle();
      n++;
    end
    chk("presc_restart", n, 4);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sample_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      nrst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
